// File: rtl/vx_pe_imul_array.sv
// vx_pe_imul_array
// NUM_PES independent, fixed-latency RV32M/RV64M multiply pipelines that share
// a single advance strobe. No valid/tag state lives here: the upstream
// serializer tracks which enabled cycle carries a real operation.
`timescale 1ns/1ps

module vx_pe_imul_array #(
   parameter int NUM_PES = 1,
   parameter int XLEN    = 32,
   parameter int LATENCY = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_PES*(2+2*XLEN)-1:0] data_in,
   output logic [NUM_PES*XLEN-1:0]       data_out
);

   localparam int IN_W = 2 + 2*XLEN;
   // The full signed (XLEN+1)x(XLEN+1) product is 2*XLEN+2 bits wide, but only
   // bits [2*XLEN-1:0] are ever selected, so the multiply is carried out
   // modulo 2^(2*XLEN). Those low bits are identical to the full product's.
   localparam int PW   = 2*XLEN;
   // Pure delay registers between the product register and the output stage.
   localparam int NDLY = (LATENCY > 2) ? LATENCY - 2 : 0;

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("vx_pe_imul_array: LATENCY must be in the range 1..4");
   end

   genvar gi;
   for (gi = 0; gi < NUM_PES; gi++) begin : g_pe
      logic [1:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic            a_sgn;
      logic            b_sgn;
      logic [XLEN:0]   a_ext;
      logic [XLEN:0]   b_ext;
      logic            sel_hi;

      assign {op, a, b} = data_in[gi*IN_W +: IN_W];

      // a is signed for MULH and MULHSU, b only for MULH.
      assign a_sgn  = (op == 2'd1) || (op == 2'd2);
      assign b_sgn  = (op == 2'd1);
      assign a_ext  = {a_sgn & a[XLEN-1], a};
      assign b_ext  = {b_sgn & b[XLEN-1], b};
      assign sel_hi = (op != 2'd0);

      logic [XLEN:0] a_src;
      logic [XLEN:0] b_src;
      logic          sel_src;

      if (LATENCY == 1) begin : g_no_stage1
         // Single-stage build: extend/multiply/select all feed the output reg.
         assign a_src   = a_ext;
         assign b_src   = b_ext;
         assign sel_src = sel_hi;
      end else begin : g_stage1
         logic [XLEN:0] a_ext_reg;
         logic [XLEN:0] b_ext_reg;
         logic          sel_hi_reg;

         // Stage 1: capture the extended operands and the half select.
         always_ff @(posedge clk) begin
            if (reset) begin
               a_ext_reg  <= '0;
               b_ext_reg  <= '0;
               sel_hi_reg <= 1'b0;
            end else if (enable) begin
               a_ext_reg  <= a_ext;
               b_ext_reg  <= b_ext;
               sel_hi_reg <= sel_hi;
            end
         end

         assign a_src   = a_ext_reg;
         assign b_src   = b_ext_reg;
         assign sel_src = sel_hi_reg;
      end

      // Sign-extend the (XLEN+1)-bit operands to PW bits; an unsigned PW-bit
      // multiply then yields the low PW bits of the signed product.
      logic [PW-1:0] a_wide;
      logic [PW-1:0] b_wide;
      logic [PW-1:0] product;

      assign a_wide  = {{(XLEN-1){a_src[XLEN]}}, a_src};
      assign b_wide  = {{(XLEN-1){b_src[XLEN]}}, b_src};
      assign product = a_wide * b_wide;

      logic [PW-1:0] prod_last;
      logic          sel_last;

      if (NDLY == 0) begin : g_no_dly
         assign prod_last = product;
         assign sel_last  = sel_src;
      end else begin : g_dly
         logic [PW-1:0] prod_dly_reg [0:NDLY-1];
         logic          sel_dly_reg  [0:NDLY-1];

         // Product register (stage 2) followed by pure delay stages.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < NDLY; i++) begin
                  prod_dly_reg[i] <= '0;
                  sel_dly_reg[i]  <= 1'b0;
               end
            end else if (enable) begin
               prod_dly_reg[0] <= product;
               sel_dly_reg[0]  <= sel_src;
               for (int i = 1; i < NDLY; i++) begin
                  prod_dly_reg[i] <= prod_dly_reg[i-1];
                  sel_dly_reg[i]  <= sel_dly_reg[i-1];
               end
            end
         end

         assign prod_last = prod_dly_reg[NDLY-1];
         assign sel_last  = sel_dly_reg[NDLY-1];
      end

      logic [XLEN-1:0] out_reg;

      // Last stage: pick the low or high half into the output register.
      always_ff @(posedge clk) begin
         if (reset) begin
            out_reg <= '0;
         end else if (enable) begin
            out_reg <= sel_last ? prod_last[PW-1:XLEN] : prod_last[XLEN-1:0];
         end
      end

      assign data_out[gi*XLEN +: XLEN] = out_reg;
   end

endmodule

// File: tb/tb_vx_pe_imul_array.sv
// Testbench for vx_pe_imul_array: directed vector tables, stall and
// mid-flight reset sequences, a 64-bit latency sweep and a random run.
`timescale 1ns/1ps

module tb_vx_pe_imul_array;

   localparam int NP   = 4;
   localparam int IW32 = 2 + 2*32;
   localparam int IW64 = 2 + 2*64;

   logic                  clk;
   logic                  reset;
   logic                  enable;
   logic [NP*IW32-1:0]    din_m;
   logic [NP*32-1:0]      dout_m;
   logic [IW64-1:0]       din64;
   logic [63:0]           out_l1;
   logic [63:0]           out_l2;
   logic [63:0]           out_l4;

   int n_checks = 0;
   int n_errors = 0;

   vx_pe_imul_array #(.NUM_PES(NP), .XLEN(32), .LATENCY(3)) dut_main (
      .clk(clk), .reset(reset), .enable(enable), .data_in(din_m), .data_out(dout_m));
   vx_pe_imul_array #(.NUM_PES(1), .XLEN(64), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .enable(enable), .data_in(din64), .data_out(out_l1));
   vx_pe_imul_array #(.NUM_PES(1), .XLEN(64), .LATENCY(2)) dut_l2 (
      .clk(clk), .reset(reset), .enable(enable), .data_in(din64), .data_out(out_l2));
   vx_pe_imul_array #(.NUM_PES(1), .XLEN(64), .LATENCY(4)) dut_l4 (
      .clk(clk), .reset(reset), .enable(enable), .data_in(din64), .data_out(out_l4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec32_t;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec64_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic en);
      enable = en;
      @(posedge clk);
      #1;
   endtask

   task automatic set_pe(input int pe, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      din_m[pe*IW32 +: IW32] = {op, a, b};
   endtask

   function automatic logic [31:0] pe_out(input int pe);
      return dout_m[pe*32 +: 32];
   endfunction

   task automatic do_reset();
      din_m  = '0;
      din64  = '0;
      reset  = 1'b1;
      step(1'b0);
      reset  = 1'b0;
   endtask

   // Independent golden model: 64-bit arithmetic on 32-bit operands.
   function automatic logic [31:0] golden32(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] p;
      longint      sa;
      longint      sb;
      longint      ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      case (op)
         2'd1:    p = 64'(sa * sb);
         2'd2:    p = 64'(sa * ub);
         default: p = {32'd0, a} * {32'd0, b};
      endcase
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vec32_t v32 [10];
      vec64_t v64 [4];
      logic [31:0] hist [NP][3];
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        en;
      int          k;
      int          cyc;
      logic [31:0] exp_v;
      int          pat [6];

      // Expected values computed by hand.
      v32[0] = '{2'd0, 32'd3,         32'd5,         32'd15};
      v32[1] = '{2'd0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
      v32[2] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      v32[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      v32[4] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      v32[5] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      v32[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      v32[7] = '{2'd3, 32'h8000_0000, 32'd2,         32'h0000_0001};
      v32[8] = '{2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
      v32[9] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};

      v64[0] = '{2'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2};
      v64[1] = '{2'd0, 64'h8000_0000_0000_0000, 64'd4, 64'd0};
      v64[2] = '{2'd1, 64'h8000_0000_0000_0000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE};
      v64[3] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};

      pat = '{1, 0, 0, 1, 1, 0};

      reset  = 1'b0;
      enable = 1'b0;
      din_m  = '0;
      din64  = '0;

      // Reset state.
      do_reset();
      check("reset_main", {32'd0, dout_m[31:0]} | {32'd0, dout_m[127:96]} |
            {32'd0, dout_m[95:64]} | {32'd0, dout_m[63:32]}, 64'd0);
      check("reset_l1", out_l1, 64'd0);
      check("reset_l2", out_l2, 64'd0);
      check("reset_l4", out_l4, 64'd0);

      // Back-to-back vector table: PE0 in order, PE1 in reverse order.
      for (int i = 0; i < 12; i++) begin
         if (i < 10) begin
            set_pe(0, v32[i].op, v32[i].a, v32[i].b);
            set_pe(1, v32[9-i].op, v32[9-i].a, v32[9-i].b);
         end else begin
            set_pe(0, 2'd0, 32'd0, 32'd0);
            set_pe(1, 2'd0, 32'd0, 32'd0);
         end
         step(1'b1);
         if (i >= 2) begin
            check($sformatf("vec%0d_pe0", i-2), {32'd0, pe_out(0)}, {32'd0, v32[i-2].exp});
            check($sformatf("vec%0d_pe1", 11-i), {32'd0, pe_out(1)}, {32'd0, v32[11-i].exp});
            $display("vec %0d: op=%0d a=%h b=%h -> %h", i-2, v32[i-2].op, v32[i-2].a,
                     v32[i-2].b, pe_out(0));
         end else begin
            check($sformatf("early%0d_pe0", i), {32'd0, pe_out(0)}, 64'd0);
            check($sformatf("early%0d_pe1", i), {32'd0, pe_out(1)}, 64'd0);
         end
      end

      // Stall: operands 1..6 times 7 under an irregular enable pattern.
      do_reset();
      k     = 0;
      cyc   = 0;
      exp_v = 32'd0;
      while (k < 9 && cyc < 40) begin
         en = (pat[cyc % 6] != 0);
         if (en)
            set_pe(0, 2'd0, (k < 6) ? 32'(k + 1) : 32'd0, (k < 6) ? 32'd7 : 32'd0);
         else
            set_pe(0, 2'd3, 32'd99, 32'd99);
         step(en);
         if (en) begin
            k++;
            exp_v = (k >= 3 && k <= 8) ? 32'(7 * (k - 2)) : 32'd0;
         end
         check($sformatf("stall_cyc%0d", cyc), {32'd0, pe_out(0)}, {32'd0, exp_v});
         $display("stall cyc %0d: en=%0d out=%0d", cyc, en, pe_out(0));
         cyc++;
      end
      check("stall_done", 64'(k), 64'd9);

      // Reset mid-flight: in-flight results and the reset-cycle input are lost.
      do_reset();
      set_pe(0, 2'd0, 32'd5, 32'd5); step(1'b1);
      set_pe(0, 2'd0, 32'd6, 32'd6); step(1'b1);
      set_pe(0, 2'd0, 32'd7, 32'd7); step(1'b1);
      check("pre_reset_25", {32'd0, pe_out(0)}, 64'd25);
      set_pe(0, 2'd0, 32'd9, 32'd9);
      reset = 1'b1;
      step(1'b1);
      reset = 1'b0;
      check("after_reset", {32'd0, pe_out(0)}, 64'd0);
      set_pe(0, 2'd0, 32'd4, 32'd4); step(1'b1);
      check("rst_e1", {32'd0, pe_out(0)}, 64'd0);
      set_pe(0, 2'd0, 32'd0, 32'd0); step(1'b1);
      check("rst_e2", {32'd0, pe_out(0)}, 64'd0);
      step(1'b1);
      check("rst_e3_16", {32'd0, pe_out(0)}, 64'd16);
      $display("reset mid-flight: MUL(4,4) -> %0d", pe_out(0));
      step(1'b1);
      check("rst_e4", {32'd0, pe_out(0)}, 64'd0);

      // XLEN=64 sweep over LATENCY 1, 2 and 4.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         din64 = {v64[v].op, v64[v].a, v64[v].b};
         for (int s = 1; s <= 5; s++) begin
            step(1'b1);
            din64 = '0;
            check($sformatf("l1_v%0d_s%0d", v, s), out_l1, (s == 1) ? v64[v].exp : 64'd0);
            check($sformatf("l2_v%0d_s%0d", v, s), out_l2, (s == 2) ? v64[v].exp : 64'd0);
            check($sformatf("l4_v%0d_s%0d", v, s), out_l4, (s == 4) ? v64[v].exp : 64'd0);
         end
         $display("sweep vec %0d: op=%0d exp=%h", v, v64[v].op, v64[v].exp);
      end

      // Random run against the golden model with ~50% enable.
      do_reset();
      for (int p = 0; p < NP; p++)
         for (int d = 0; d < 3; d++)
            hist[p][d] = 32'd0;
      for (int c = 0; c < 20000; c++) begin
         logic [31:0] nxt [NP];
         en = ($urandom_range(0, 1) == 1);
         for (int p = 0; p < NP; p++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            set_pe(p, rop, ra, rb);
            nxt[p] = golden32(rop, ra, rb);
         end
         step(en);
         for (int p = 0; p < NP; p++) begin
            if (en) begin
               hist[p][2] = hist[p][1];
               hist[p][1] = hist[p][0];
               hist[p][0] = nxt[p];
            end
            check($sformatf("rand_c%0d_pe%0d", c, p), {32'd0, pe_out(p)}, {32'd0, hist[p][2]});
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
